mult_seq_ctl: RTL and testbench
===============================

// Module: mult_seq_ctl
// PURPOSE
// - Sequencer for the iterative shift-add multiplier that executes MULTU/MADDU in EX.
// - Accepts one op from the decode/ALU-control side and issues one init pulse, then WIDTH step enables.
// - Issues one HI/LO write strobe at the end of the op.
// - Stalls the pipeline when it issues MFHI/MFLO before the result is written.
// PARAMETERS
// - WIDTH   32  operand width = number of step cycles
// - CNT_W    6  step counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk          in   1      system clock; all state updates on posedge
// - rst_n        in   1      reset, synchronous, active-low
// - start        in   1      request a new multiply op (level, sampled each cycle)
// - op           in   2      00=MULTU, 01=MADDU, 1x=illegal (request ignored)
// - flush        in   1      abort the op in flight (branch/exception squash)
// - rd_hilo_req  in   1      MFHI/MFLO present in EX
// - accept       out  1      start taken this cycle
// - busy         out  1      op in flight (INIT, RUN or WB)
// - mult_start   out  1      1-cycle pulse: datapath loads operands, clears partial product
// - mult_step    out  1      datapath performs one shift-add iteration
// - step_cnt     out  CNT_W  completed iterations of the current op
// - acc_sel      out  1      0=HI/LO <= product, 1=HI/LO <= HI/LO + product (MADDU)
// - hilo_we      out  1      HI/LO write strobe (1 cycle)
// - done         out  1      op-complete pulse, coincident with hilo_we
// - stall        out  1      hold IF/ID/EX this cycle
// BEHAVIOUR
// - States: IDLE, INIT, RUN, WB. Reset (rst_n=0 at posedge) forces IDLE and sets all outputs to 0.
//   - Reset also clears step_cnt and acc_sel.
//   - Reset mid-op: the op is dropped with no hilo_we.
// - IDLE: start=1 with legal op -> accept=1, latch acc_sel=op[0], go to INIT.
//   - Illegal op -> accept=0, stay in IDLE.
// - INIT (1 cycle): mult_start=1, step_cnt<=0, then go to RUN.
// - RUN: mult_step=1 every cycle, step_cnt increments.
//   - When step_cnt reaches WIDTH-1 and that step completes, go to WB.
// - WB (1 cycle): hilo_we=1, done=1.
//   - Next state is INIT if start=1 with a legal op (back-to-back, accept=1), else IDLE.
// - Latency: start sampled at edge N -> mult_start in cycle N+1 -> mult_step in cycles N+2..N+WIDTH+1.
//   - hilo_we/done in cycle N+WIDTH+2.
//   - Throughput: one op per WIDTH+2 cycles.
// - busy = (state != IDLE). start while busy, outside WB -> accept=0; requester holds start.
// - stall = rd_hilo_req & busy. This includes WB, because HI/LO is written at the end of WB.
//   - MFHI/MFLO proceeds the cycle after WB.
// - flush: highest priority after reset.
//   - In INIT/RUN/WB: next state IDLE, no hilo_we that cycle or later, step_cnt<=0.
//   - flush in the WB cycle suppresses hilo_we and done in that same cycle.
//   - flush with start in the same cycle: start is ignored, accept=0.
// - step_cnt holds its final value WIDTH in WB/IDLE until the next INIT.
// - acc_sel is constant from INIT through WB.
// - All outputs are registered or decoded from state only. No combinational path from start to mult_step.
//   - accept and stall may decode from inputs.
// CONFIGURATION
// - MULT_PERF_CNT_EN defined: adds output stall_cycles [15:0].
//   - Increments on every cycle with stall=1, saturates at 16'hFFFF, cleared by reset only.
// - MULT_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - MULTU (WIDTH=32): start=1, op=00 at edge 0.
//   -> accept@0, mult_start@1, mult_step@2..33, hilo_we=done=1 @34, acc_sel=0, busy=0 @35.
// - MADDU back-to-back: start held high with op=01.
//   -> second accept in WB cycle 34, mult_start@35, second done@68, acc_sel=1 throughout.
// - Hazard: rd_hilo_req=1 from cycle 10.
//   -> stall=1 cycles 10..34, stall=0 @35.
//   -> with MULT_PERF_CNT_EN, stall_cycles=25.
// - Flush at cycle 20 of a MULTU.
//   -> state IDLE @21, no hilo_we/done ever, step_cnt=0.
//   - Flush in the WB cycle: hilo_we suppressed.
// - rst_n=0 at cycle 15 mid-RUN.
//   -> all outputs 0 @16; start ignored during reset; new op after release completes normally.
// - Illegal op=10 with start=1 in IDLE.
//   -> accept=0, busy=0, no mult_start.

Source files
------------

// File: rtl/mult_seq_ctl.sv
// Sequencer for the iterative shift-add multiplier (MULTU/MADDU): init pulse, WIDTH steps, HI/LO write.
// Optional MULT_PERF_CNT_EN adds a saturating stall_cycles counter output.
module mult_seq_ctl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic             rd_hilo_req,
    output logic             accept,
    output logic             busy,
    output logic             mult_start,
    output logic             mult_step,
    output logic [CNT_W-1:0] step_cnt,
    output logic             acc_sel,
    output logic             hilo_we,
    output logic             done,
    output logic             stall,
`ifdef MULT_PERF_CNT_EN
    output logic [15:0]      stall_cycles,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Handshake: a request is taken in the cycle where start=1, op is legal and accept=1.
    // The requester keeps start high until it sees accept; there is no separate ready.
    state_t state, state_nxt;
    logic   legal_req;
    logic   last_step;

    assign legal_req = start & ~op[1];
    assign last_step = (step_cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != S_IDLE);
    assign stall     = rd_hilo_req & busy;
    assign state_dbg = state;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        mult_start = 1'b0;
        mult_step  = 1'b0;
        hilo_we    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (legal_req && !flush && rst_n) begin
                    accept    = 1'b1;
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                mult_start = 1'b1;
                state_nxt  = flush ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                mult_step = 1'b1;
                if (flush)          state_nxt = S_IDLE;
                else if (last_step) state_nxt = S_WB;
            end
            S_WB: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    // A reset edge closing this cycle drops the op, so no write.
                    hilo_we = rst_n;
                    done    = rst_n;
                    if (legal_req && rst_n) begin
                        accept    = 1'b1;
                        state_nxt = S_INIT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            acc_sel  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) acc_sel <= op[0];
            // step_cnt keeps its final count in WB/IDLE until the next op starts.
            if (flush && busy)         step_cnt <= '0;
            else if (accept)           step_cnt <= '0;
            else if (state == S_INIT)  step_cnt <= '0;
            else if (state == S_RUN)   step_cnt <= step_cnt + CNT_W'(1);
        end
    end

`ifdef MULT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                            stall_cycles <= '0;
        else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mult_seq_ctl.sv
// Self-checking bench for mult_seq_ctl: directed scenarios plus random traffic against
// an op-age reference model and a scoreboard of expected accumulate selects.
module tb_mult_seq_ctl;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n, start, flush, rd_hilo_req;
    logic [1:0]       op;
    logic             accept, busy, mult_start, mult_step, acc_sel, hilo_we, done, stall;
    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       state_dbg;
`ifdef MULT_PERF_CNT_EN
    logic [15:0]      stall_cycles;
`endif

    always #5 clk = ~clk;

    mult_seq_ctl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
        .rd_hilo_req(rd_hilo_req), .accept(accept), .busy(busy),
        .mult_start(mult_start), .mult_step(mult_step), .step_cnt(step_cnt),
        .acc_sel(acc_sel), .hilo_we(hilo_we), .done(done), .stall(stall),
`ifdef MULT_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .state_dbg(state_dbg)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: an op in flight is described only by its age in cycles since accept.
    bit       m_busy = 0;
    int       m_age  = 0;
    bit       m_acc  = 0;
    int       m_cnt  = 0;
    int       m_stall = 0;
    logic [0:0] exp_q[$];

    int cyc = 0;
    int dut_dones = 0, dut_stalls = 0, dut_starts = 0, last_done_cyc = -1;
    int c0, d0, s0, ms0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit e_wb, e_acc, e_we, e_stall;
        logic [0:0] front;
        @(negedge clk);
        e_wb    = m_busy && (m_age == WIDTH + 2);
        e_acc   = rst_n && !flush && start && !op[1] && (!m_busy || e_wb);
        e_we    = e_wb && !flush && rst_n;
        e_stall = rd_hilo_req && m_busy;
        check("accept", accept, e_acc);
        check("busy", busy, m_busy);
        check("mult_start", mult_start, m_busy && m_age == 1);
        check("mult_step", mult_step, m_busy && m_age >= 2 && m_age <= WIDTH + 1);
        check("hilo_we", hilo_we, e_we);
        check("done", done, e_we);
        check("stall", stall, e_stall);
        check("step_cnt", step_cnt, m_cnt);
        check("acc_sel", acc_sel, m_acc);
`ifdef MULT_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
        if (e_we) begin
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                front = exp_q.pop_front();
                check("sb_acc_sel", acc_sel, front);
            end
        end
        if (done === 1'b1) begin dut_dones++; last_done_cyc = cyc; end
        if (stall === 1'b1) dut_stalls++;
        if (mult_start === 1'b1) dut_starts++;
        @(posedge clk);
        if (!rst_n) m_stall = 0;
        else if (e_stall && m_stall < 65535) m_stall++;
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0; m_acc = 0; exp_q.delete();
        end else if (flush && m_busy) begin
            m_busy = 0; m_cnt = 0; exp_q.delete();
        end else if (e_acc) begin
            m_busy = 1; m_age = 1; m_acc = op[0]; m_cnt = 0; exp_q.push_back(op[0]);
        end else if (m_busy) begin
            if (m_age >= 2 && m_age <= WIDTH + 1) m_cnt = m_age - 1;
            if (m_age == WIDTH + 2) m_busy = 0;
            else m_age++;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit s, input logic [1:0] o, input bit f, input bit r,
                         input bit rn, input int n);
        start = s; op = o; flush = f; rd_hilo_req = r; rst_n = rn;
        repeat (n) run_cycle();
    endtask

    initial begin
        start = 0; op = 0; flush = 0; rd_hilo_req = 0; rst_n = 0;
        #1;
        drive(0, 2'b00, 0, 0, 0, 3);
        drive(0, 2'b00, 0, 0, 1, 2);

        // MULTU: done expected 34 cycles after the accepting cycle
        c0 = cyc; d0 = dut_dones;
        drive(1, 2'b00, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 36);
        check("multu_done_count", dut_dones - d0, 1);
        check("multu_done_cycle", last_done_cyc - c0, 34);

        // MADDU back-to-back with start held high
        c0 = cyc; d0 = dut_dones;
        drive(1, 2'b01, 0, 0, 1, 68);
        drive(0, 2'b00, 0, 0, 1, 40);
        check("maddu_done_count", dut_dones - d0, 2);
        check("maddu_second_done_cycle", last_done_cyc - c0, 68);

        // MFHI/MFLO hazard from cycle 10
        s0 = dut_stalls;
        drive(1, 2'b00, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 9);
        drive(0, 2'b00, 0, 1, 1, 27);
        check("hazard_stall_cycles", dut_stalls - s0, 25);
        drive(0, 2'b00, 0, 0, 1, 2);

        // Flush mid-RUN at cycle 20
        d0 = dut_dones;
        drive(1, 2'b00, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 19);
        drive(1, 2'b00, 1, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 40);
        check("flush_run_no_done", dut_dones - d0, 0);

        // Flush in the WB cycle
        d0 = dut_dones;
        drive(1, 2'b01, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 33);
        drive(0, 2'b00, 1, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 5);
        check("flush_wb_no_done", dut_dones - d0, 0);

        // Reset mid-RUN at cycle 15 with start asserted, then a fresh op
        d0 = dut_dones;
        drive(1, 2'b00, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 14);
        drive(1, 2'b00, 0, 0, 0, 1);
        drive(0, 2'b00, 0, 0, 1, 1);
        check("reset_drop_no_done", dut_dones - d0, 0);
        drive(1, 2'b01, 0, 0, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 36);
        check("after_reset_done", dut_dones - d0, 1);

        // Illegal ops are ignored
        ms0 = dut_starts;
        drive(1, 2'b10, 0, 0, 1, 3);
        drive(1, 2'b11, 0, 0, 1, 3);
        drive(0, 2'b00, 0, 0, 1, 2);
        check("illegal_no_mult_start", dut_starts - ms0, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            start       = 1'($urandom_range(0, 1));
            op          = 2'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 99) < 2);
            rd_hilo_req = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 199) != 0);
            run_cycle();
        end
        drive(0, 2'b00, 0, 0, 1, 40);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
